// File: rtl/fetch_seq.sv
// Program-counter sequencer for the fetch stage. It handles program select and load,
// run/stall/halt, relative branch, absolute jump, and call/return over a LIFO return stack.
module fetch_seq #(
  parameter int PC_W        = 10,
  parameter int OFF_W       = 8,
  parameter int NPROG       = 4,
  parameter int PROG_STRIDE = 256,
  parameter int STACK_D     = 4,
  parameter int PS_W        = (NPROG > 1) ? $clog2(NPROG) : 1,
  parameter int D_W         = $clog2(STACK_D + 1)
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic [PS_W-1:0]   ProgSel,
  input  logic              Stall,
  input  logic              BranchRelEn,
  input  logic              ALU_flag,
  input  logic [OFF_W-1:0]  Offset,
  input  logic              JumpEn,
  input  logic              CallEn,
  input  logic              RetEn,
  input  logic              Halt,
  input  logic [PC_W-1:0]   Target,
  output logic [PC_W-1:0]   ProgCtr,
  output logic              Running,
  output logic              Done,
  output logic [D_W-1:0]    Depth,
  output logic              StackErr
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  localparam int IDX_W = (STACK_D > 1) ? $clog2(STACK_D) : 1;
  localparam logic [D_W-1:0] FULL = D_W'(STACK_D);

  logic [1:0]       state_reg, state_next;
  logic [PC_W-1:0]  pc_reg, pc_next;
  logic [D_W-1:0]   depth_reg, depth_next;
  logic             err_reg, err_next;
  logic             push_en;
  logic [PC_W-1:0]  pc_inc;
  logic [PC_W-1:0]  off_ext;
  logic [IDX_W-1:0] push_idx, pop_idx;
  logic [PC_W-1:0]  stack_mem [0:STACK_D-1];
  logic [PC_W-1:0]  base_tbl  [0:(1<<PS_W)-1];

  // Out-of-range program indices resolve to program 0 through this table.
  for (genvar gi = 0; gi < (1 << PS_W); gi++) begin : g_base
    if (gi < NPROG) begin : g_valid
      assign base_tbl[gi] = PC_W'(gi * PROG_STRIDE);
    end else begin : g_map0
      assign base_tbl[gi] = '0;
    end
  end

  assign pc_inc   = pc_reg + 1'b1;
  assign off_ext  = PC_W'($signed(Offset));
  assign push_idx = IDX_W'(depth_reg);
  assign pop_idx  = IDX_W'(depth_reg - 1'b1);

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    depth_next = depth_reg;
    err_next   = err_reg;
    push_en    = 1'b0;
    if (Start) begin
      state_next = S_LOAD;
      pc_next    = base_tbl[ProgSel];
      depth_next = '0;
      err_next   = 1'b0;
    end else begin
      case (state_reg)
        S_LOAD: state_next = S_RUN;
        S_RUN: begin
          if (!Stall) begin
            if (Halt) begin
              state_next = S_HALTED;
            end else if (RetEn) begin
              if (depth_reg != '0) begin
                pc_next    = stack_mem[pop_idx];
                depth_next = depth_reg - 1'b1;
              end else begin
                err_next = 1'b1;
                pc_next  = pc_inc;
              end
            end else if (CallEn) begin
              if (depth_reg != FULL) begin
                push_en    = 1'b1;
                pc_next    = Target;
                depth_next = depth_reg + 1'b1;
              end else begin
                err_next = 1'b1;
                pc_next  = pc_inc;
              end
            end else if (JumpEn) begin
              pc_next = Target;
            end else if (BranchRelEn && ALU_flag) begin
              pc_next = pc_inc + off_ext;
            end else begin
              pc_next = pc_inc;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_reg <= S_IDLE;
      pc_reg    <= '0;
      depth_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      depth_reg <= depth_next;
      err_reg   <= err_next;
    end
  end

  // Stack storage carries no reset; entries above Depth are never read.
  always_ff @(posedge Clk) begin
    if (push_en && Reset_n) begin
      stack_mem[push_idx] <= pc_inc;
    end
  end

  assign ProgCtr  = pc_reg;
  assign Depth    = depth_reg;
  assign StackErr = err_reg;
  assign Running  = (state_reg == S_RUN);
  assign Done     = (state_reg == S_HALTED);

endmodule

// File: tb/tb_fetch_seq.sv
// Self-checking bench for fetch_seq: directed scenarios with literal expectations, then
// randomized strobes against a queue-based behavioural model compared on every cycle.
module tb_fetch_seq;

  localparam int PC_W  = 10;
  localparam int NPROG = 5;
  localparam int MODV  = 1 << PC_W;

  logic       Clk = 1'b0;
  logic       Reset_n, Start, Stall, BranchRelEn, ALU_flag, JumpEn, CallEn, RetEn, Halt;
  logic [2:0] ProgSel;
  logic [7:0] Offset;
  logic [9:0] Target;
  logic [9:0] ProgCtr;
  logic       Running, Done, StackErr;
  logic [2:0] Depth;

  fetch_seq #(.PC_W(PC_W), .OFF_W(8), .NPROG(NPROG), .PROG_STRIDE(256), .STACK_D(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .ProgSel(ProgSel), .Stall(Stall),
    .BranchRelEn(BranchRelEn), .ALU_flag(ALU_flag), .Offset(Offset), .JumpEn(JumpEn),
    .CallEn(CallEn), .RetEn(RetEn), .Halt(Halt), .Target(Target), .ProgCtr(ProgCtr),
    .Running(Running), .Done(Done), .Depth(Depth), .StackErr(StackErr)
  );

  always #5 Clk = ~Clk;

  typedef enum int {M_IDLE, M_LOAD, M_RUN, M_HALT} mode_t;
  mode_t m_mode;
  int    m_pc;
  int    m_err;
  int    m_stk[$];
  bit    active = 1'b0;
  int    n_checks = 0;
  int    n_fail = 0;
  int    cyc = 0;

  function automatic int prog_base(int sel);
    return (sel < NPROG) ? (sel * 256) % MODV : 0;
  endfunction

  // Model advances using the inputs that the DUT saw on the same edge.
  task automatic model_step();
    int soff;
    if (!Reset_n) begin
      m_mode = M_IDLE; m_pc = 0; m_err = 0; m_stk.delete();
    end else if (Start) begin
      m_mode = M_LOAD; m_pc = prog_base(int'(ProgSel)); m_err = 0; m_stk.delete();
    end else if (m_mode == M_LOAD) begin
      m_mode = M_RUN;
    end else if (m_mode == M_RUN && !Stall) begin
      if (Halt) m_mode = M_HALT;
      else if (RetEn) begin
        if (m_stk.size() > 0) m_pc = m_stk.pop_back();
        else begin m_err = 1; m_pc = (m_pc + 1) % MODV; end
      end else if (CallEn) begin
        if (m_stk.size() < 4) begin m_stk.push_back((m_pc + 1) % MODV); m_pc = int'(Target); end
        else begin m_err = 1; m_pc = (m_pc + 1) % MODV; end
      end else if (JumpEn) m_pc = int'(Target);
      else if (BranchRelEn && ALU_flag) begin
        soff = int'($signed(Offset));
        m_pc = ((m_pc + soff + 1) % MODV + MODV) % MODV;
      end else m_pc = (m_pc + 1) % MODV;
    end
  endtask

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic clear_strobes();
    Start = 0; Stall = 0; BranchRelEn = 0; ALU_flag = 0; JumpEn = 0;
    CallEn = 0; RetEn = 0; Halt = 0; Offset = '0; Target = '0;
  endtask

  task automatic step();
    @(posedge Clk);
    model_step();
    active = 1'b1;
    cyc++;
    @(negedge Clk);
  endtask

  // Single compare process: DUT against model on every cycle after the first reset edge.
  always @(negedge Clk) begin
    if (active) begin
      chk("model_pc", int'(ProgCtr), m_pc);
      chk("model_running", int'(Running), int'(m_mode == M_RUN));
      chk("model_done", int'(Done), int'(m_mode == M_HALT));
      chk("model_depth", int'(Depth), m_stk.size());
      chk("model_err", int'(StackErr), m_err);
    end
  end

  initial begin
    clear_strobes();
    Reset_n = 0; ProgSel = '0;
    m_mode = M_IDLE; m_pc = 0; m_err = 0;
    @(negedge Clk);
    step(); step();
    chk("reset_pc", int'(ProgCtr), 0);
    chk("reset_flags", int'({Running, Done, StackErr}), 0);

    Reset_n = 1; Start = 1; ProgSel = 3'd2;
    for (int i = 0; i < 3; i++) begin step(); chk("start_hold_pc", int'(ProgCtr), 512); end
    Start = 0;
    step(); chk("first_run_pc", int'(ProgCtr), 512); chk("running", int'(Running), 1);
    step(); chk("run_pc1", int'(ProgCtr), 513);
    step(); chk("run_pc2", int'(ProgCtr), 514);

    JumpEn = 1; Target = 10'd520; step(); JumpEn = 0;
    BranchRelEn = 1; ALU_flag = 1; Offset = 8'hF8; step();
    chk("branch_taken", int'(ProgCtr), 513);
    BranchRelEn = 0; JumpEn = 1; Target = 10'd520; step(); JumpEn = 0;
    BranchRelEn = 1; ALU_flag = 0; step(); BranchRelEn = 0;
    chk("branch_not_taken", int'(ProgCtr), 521);
    JumpEn = 1; Target = 10'd1023; step(); JumpEn = 0;
    step(); chk("pc_wrap", int'(ProgCtr), 0);

    JumpEn = 1; Target = 10'd600; step(); JumpEn = 0;
    CallEn = 1; Target = 10'd100; step(); CallEn = 0;
    chk("call1_pc", int'(ProgCtr), 100); chk("call1_depth", int'(Depth), 1);
    for (int i = 0; i < 5; i++) step();
    CallEn = 1; Target = 10'd200; step(); CallEn = 0;
    chk("call2_depth", int'(Depth), 2);
    RetEn = 1; step(); chk("ret1_pc", int'(ProgCtr), 106);
    step(); RetEn = 0;
    chk("ret2_pc", int'(ProgCtr), 601); chk("ret2_depth", int'(Depth), 0);

    CallEn = 1; Target = 10'd300;
    for (int i = 0; i < 5; i++) step();
    CallEn = 0;
    chk("overflow_pc", int'(ProgCtr), 301); chk("overflow_depth", int'(Depth), 4);
    chk("overflow_err", int'(StackErr), 1);
    Start = 1; ProgSel = 3'd1; step(); Start = 0;
    chk("start_clears_err", int'(StackErr), 0);
    step();
    RetEn = 1; step(); RetEn = 0;
    chk("underflow_err", int'(StackErr), 1); chk("underflow_pc", int'(ProgCtr), 257);

    Stall = 1; JumpEn = 1; Target = 10'd9; step(); Stall = 0;
    chk("stall_hold", int'(ProgCtr), 257);
    Target = 10'd530; step(); JumpEn = 0;
    Halt = 1; step(); Halt = 0;
    JumpEn = 1; Target = 10'd7;
    for (int i = 0; i < 10; i++) begin
      step(); chk("halt_pc", int'(ProgCtr), 530); chk("halt_done", int'(Done), 1);
    end
    JumpEn = 0;
    Start = 1; ProgSel = 3'd5; step(); Start = 0;
    chk("bad_sel_pc", int'(ProgCtr), 0);
    step();
    CallEn = 1; Target = 10'd40;
    for (int i = 0; i < 3; i++) step();
    CallEn = 0;
    chk("pre_reset_depth", int'(Depth), 3);
    Reset_n = 0; step(); Reset_n = 1;
    chk("midrun_reset_pc", int'(ProgCtr), 0); chk("midrun_reset_depth", int'(Depth), 0);
    chk("midrun_reset_flags", int'({Running, Done, StackErr}), 0);

    for (int i = 0; i < 3000; i++) begin
      Reset_n     = ($urandom_range(0, 199) != 0);
      Start       = ($urandom_range(0, 39) == 0);
      ProgSel     = 3'($urandom_range(0, 7));
      Stall       = ($urandom_range(0, 7) == 0);
      Halt        = ($urandom_range(0, 59) == 0);
      RetEn       = ($urandom_range(0, 5) == 0);
      CallEn      = ($urandom_range(0, 4) == 0);
      JumpEn      = ($urandom_range(0, 9) == 0);
      BranchRelEn = ($urandom_range(0, 3) == 0);
      ALU_flag    = 1'($urandom_range(0, 1));
      Offset      = 8'($urandom_range(0, 255));
      Target      = 10'($urandom_range(0, 1023));
      step();
    end

    @(posedge Clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_seq.md
# fetch_seq

Parametrised program-counter sequencer for the fetch stage. It selects one of several packed programs by index and holds the PC at that program's base while Start is asserted. It then runs the program with stall, relative branch, absolute jump, call/return over an internal return stack, and halt with a Done indication. It sits ahead of instruction memory and drives its address; the decode and ALU stages supply the control strobes.

## Interface
- PC_W, 10, program-counter width; all PC arithmetic is modulo 2^PC_W.
- OFF_W, 8, width of the signed relative-branch offset; OFF_W <= PC_W.
- NPROG, 4, number of selectable programs; ProgSel width PS_W = max(1, clog2(NPROG)).
- PROG_STRIDE, 256, base address of program k = k*PROG_STRIDE, truncated to PC_W.
- STACK_D, 4, return-stack depth (>= 1); Depth width D_W = clog2(STACK_D+1).

Ports:
- Clk  in  1  clock; all state changes on the rising edge only.
- Reset_n  in  1  synchronous, active-low reset.
- Start  in  1  load the selected program base; hold while high.
- ProgSel  in  PS_W  program index, sampled on every edge where Start=1; values >= NPROG map to program 0.
- Stall  in  1  hold the PC and the stack this cycle.
- BranchRelEn  in  1  conditional relative branch request.
- ALU_flag  in  1  branch condition; the branch is taken only when both BranchRelEn and ALU_flag are 1.
- Offset  in  OFF_W  signed branch offset.
- JumpEn  in  1  absolute jump to Target.
- CallEn  in  1  push PC+1, then jump to Target.
- RetEn  in  1  pop the return stack into the PC.
- Halt  in  1  end of program.
- Target  in  PC_W  absolute jump/call address.
- ProgCtr  out  PC_W  program counter register.
- Running  out  1  high in RUN.
- Done  out  1  high in HALTED.
- Depth  out  D_W  current return-stack occupancy.
- StackErr  out  1  sticky overflow/underflow flag.

## Operation
- States: IDLE, LOAD, RUN, HALTED. Reset_n=0 forces IDLE, ProgCtr=0, Depth=0, StackErr=0, Running=0, Done=0. Reset takes priority over all other inputs in every state, including mid-program.
- Start=1 in any state, on any edge: next state LOAD, ProgCtr=base(ProgSel), Depth=0, StackErr=0. Start takes priority over every other input except reset.
- LOAD with Start=0: next state RUN. ProgCtr is unchanged, so the first instruction fetched is at the base.
- IDLE and HALTED with Start=0: hold all state. All control strobes are ignored.
- RUN priority, highest first:
  - Stall: hold everything.
  - Halt: go to HALTED and hold the PC.
  - RetEn: if Depth>0, ProgCtr=top of stack and Depth-1. If Depth=0, set StackErr and ProgCtr+1.
  - CallEn: if Depth<STACK_D, push ProgCtr+1, Depth+1, ProgCtr=Target. If the stack is full, set StackErr, ignore the call and use ProgCtr+1.
  - JumpEn: ProgCtr=Target.
  - Taken branch: ProgCtr = ProgCtr + sext(Offset) + 1.
  - Otherwise: ProgCtr+1.
- Arithmetic: Offset is sign-extended to PC_W and the sum is truncated, so 2^PC_W-1 incremented gives 0 and negative offsets wrap below 0.
- Return stack: LIFO of PC_W-bit entries, so the push value is also truncated modulo 2^PC_W. Contents are don't-care when popped beyond valid entries (that case cannot occur, because underflow is guarded).
- StackErr clears only on reset or Start.

## Timing
- All outputs are registered. Running and Done are decoded from the state register, with no combinational path from inputs to outputs.
- Every next-PC decision takes effect one edge after the strobe is sampled. Instruction memory sees the new address in the following cycle.
- Start to RUN takes at least 2 edges: one edge into LOAD, then one edge after Start falls.
- Halt: Done rises on the edge after Halt is sampled. ProgCtr keeps the address of the halting instruction.
- Stall=1 together with Halt/Call/Ret: the other strobes are ignored that cycle. They must be re-presented by the decoder.
- Call and Ret in the same cycle: Ret wins and the call is dropped.

## Test plan
- Reset then start: hold Reset_n=0 for 2 edges, then Start=1 with ProgSel=2 for 3 edges, then release. Expect ProgCtr=0 during reset and 512 while Start is high. Expect 512 on the first RUN cycle, then 513, 514; Running=1.
- Branch: at PC=520 with BranchRelEn=1, ALU_flag=1, Offset=-8 (0xF8), expect 513. With ALU_flag=0, expect 521. At PC=1023 with no strobes, expect wrap to 0.
- Call/return: at PC=600, CallEn with Target=100 gives 100 and Depth=1. Nested CallEn at 105 with Target=200 gives Depth=2. RetEn gives 106, then RetEn gives 601 and Depth=0.
- Stack errors: perform 5 nested calls (STACK_D=4). Expect the 5th call ignored (PC+1), Depth=4, StackErr=1. After Start, StackErr=0; then RetEn at Depth=0 sets StackErr=1 with PC+1.
- Stall/halt priority: Stall with JumpEn gives the PC held. Halt at PC=530 gives Done=1 and PC 530 held for 10 cycles despite JumpEn. Start with ProgSel=5 (>= NPROG) loads PC 0.
- Reset mid-RUN with Depth=3: on the next edge ProgCtr=0, IDLE, Depth=0, all flags 0.
